// File: rtl/ace_pkg.sv
// Shared ACE definitions: AC snoop opcodes, the request codes that need remapping,
// CRRESP bit positions and the snoop issuer FSM state type.
package ace_pkg;

   localparam logic [3:0] AC_READ_ONCE              = 4'b0000;
   localparam logic [3:0] AC_READ_SHARED            = 4'b0001;
   localparam logic [3:0] AC_READ_CLEAN             = 4'b0010;
   localparam logic [3:0] AC_READ_NOT_SHARED_DIRTY  = 4'b0011;
   localparam logic [3:0] AC_READ_UNIQUE            = 4'b0111;
   localparam logic [3:0] AC_CLEAN_SHARED           = 4'b1000;
   localparam logic [3:0] AC_CLEAN_INVALID          = 4'b1001;
   localparam logic [3:0] AC_MAKE_INVALID           = 4'b1101;

   // Request-side codes that have no AC equivalent of the same value
   localparam logic [3:0] AR_CLEAN_UNIQUE           = 4'b1011;
   localparam logic [3:0] AR_MAKE_UNIQUE            = 4'b1100;
   localparam logic [2:0] AW_WRITE_UNIQUE           = 3'b000;
   localparam logic [2:0] AW_WRITE_LINE_UNIQUE      = 3'b001;

   localparam int unsigned CR_DATA_TRANSFER = 0;
   localparam int unsigned CR_ERROR         = 1;
   localparam int unsigned CR_PASS_DIRTY    = 2;
   localparam int unsigned CR_IS_SHARED     = 3;
   localparam int unsigned CR_WAS_UNIQUE    = 4;
   localparam int unsigned CR_RESP_WIDTH    = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_RESP
   } issuer_state_e;

endpackage

// File: rtl/ace_snoop_issuer_if.sv
// Request, per-master AC/CR and aggregated-result signals of the snoop issuer.
// The slave modport is the issuer itself; master is the CCU/interconnect side.
interface ace_snoop_issuer_if #(
   parameter int unsigned NoMstPorts = 4,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned IdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
);
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic                    req_is_write_i;
   logic [3:0]              req_snoop_i;
   logic [AddrWidth-1:0]    req_addr_i;
   logic [2:0]              req_prot_i;
   logic [IdxWidth-1:0]     req_src_i;

   logic [NoMstPorts-1:0]   ac_valid_o;
   logic [NoMstPorts-1:0]   ac_ready_i;
   logic [AddrWidth-1:0]    ac_addr_o;
   logic [3:0]              ac_snoop_o;
   logic [2:0]              ac_prot_o;

   logic [NoMstPorts-1:0]   cr_valid_i;
   logic [NoMstPorts-1:0]   cr_ready_o;
   logic [5*NoMstPorts-1:0] cr_resp_i;

   logic                    rsp_valid_o;
   logic                    rsp_ready_i;
   logic [4:0]              rsp_resp_o;
   logic [NoMstPorts-1:0]   rsp_data_mask_o;
   logic                    rsp_unsupported_o;

   modport slave (
      input  req_valid_i, req_is_write_i, req_snoop_i, req_addr_i, req_prot_i, req_src_i,
      output req_ready_o,
      output ac_valid_o, ac_addr_o, ac_snoop_o, ac_prot_o,
      input  ac_ready_i,
      input  cr_valid_i, cr_resp_i,
      output cr_ready_o,
      output rsp_valid_o, rsp_resp_o, rsp_data_mask_o, rsp_unsupported_o,
      input  rsp_ready_i
   );

   modport master (
      output req_valid_i, req_is_write_i, req_snoop_i, req_addr_i, req_prot_i, req_src_i,
      input  req_ready_o,
      input  ac_valid_o, ac_addr_o, ac_snoop_o, ac_prot_o,
      output ac_ready_i,
      output cr_valid_i, cr_resp_i,
      input  cr_ready_o,
      input  rsp_valid_o, rsp_resp_o, rsp_data_mask_o, rsp_unsupported_o,
      output rsp_ready_i
   );
endinterface

// File: rtl/ace_snoop_type_enc.sv
// Maps an AR/AW AxSNOOP code to the AC snoop opcode that must be broadcast,
// flagging codes that have no snoop mapping.
module ace_snoop_type_enc
   import ace_pkg::*;
(
   input  logic       is_write,
   input  logic [3:0] snoop,
   output logic [3:0] ac_snoop,
   output logic       unsupported
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      ac_snoop    = AC_READ_ONCE;
      unsupported = 1'b0;
      if (is_write) begin
         case (snoop[2:0])
            AW_WRITE_UNIQUE:      ac_snoop = AC_CLEAN_INVALID;
            AW_WRITE_LINE_UNIQUE: ac_snoop = AC_MAKE_INVALID;
            default:              unsupported = 1'b1;
         endcase
      end else begin
         case (snoop)
            AC_READ_ONCE, AC_READ_SHARED, AC_READ_CLEAN, AC_READ_NOT_SHARED_DIRTY,
            AC_READ_UNIQUE, AC_CLEAN_SHARED, AC_CLEAN_INVALID, AC_MAKE_INVALID:
                             ac_snoop = snoop;
            AR_CLEAN_UNIQUE: ac_snoop = AC_CLEAN_INVALID;
            AR_MAKE_UNIQUE:  ac_snoop = AC_MAKE_INVALID;
            default:         unsupported = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ace_snoop_issuer.sv
// Broadcasts one snoop to every master except the originator, collects the CR
// responses and returns a single OR-aggregated result.
module ace_snoop_issuer
   import ace_pkg::*;
#(
   parameter int unsigned NoMstPorts = 4,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned IdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   ace_snoop_issuer_if.slave bus
);

   issuer_state_e         state;
   logic [NoMstPorts-1:0] ac_pend, cr_pend, data_mask;
   logic [NoMstPorts-1:0] target_mask, ac_hs, cr_hs, cr_dt, cr_ready;
   logic [4:0]            resp_agg, cr_or;
   logic [AddrWidth-1:0]  addr_q;
   logic [2:0]            prot_q;
   logic [3:0]            snoop_q, enc_snoop;
   logic                  unsupported_q, rsp_valid_q, enc_unsupported;
   logic                  req_ready, req_hs;

   ace_snoop_type_enc u_enc (
      .is_write    (bus.req_is_write_i),
      .snoop       (bus.req_snoop_i),
      .ac_snoop    (enc_snoop),
      .unsupported (enc_unsupported)
   );

   // An out-of-range source index never matches, so nothing gets excluded
   always_comb begin
      target_mask = '0;
      cr_or       = '0;
      cr_dt       = '0;
      for (int i = 0; i < NoMstPorts; i++) begin
         target_mask[i] = (bus.req_src_i != IdxWidth'(i));
         cr_dt[i]       = bus.cr_resp_i[CR_RESP_WIDTH*i + CR_DATA_TRANSFER];
         if (cr_hs[i]) cr_or = cr_or | bus.cr_resp_i[CR_RESP_WIDTH*i +: CR_RESP_WIDTH];
      end
   end

   assign req_ready = (state == ST_IDLE) && !rst_i;
   assign req_hs    = bus.req_valid_i && req_ready;
   assign ac_hs     = ac_pend & bus.ac_ready_i;
   // A master's CR is only taken once its own AC has gone through
   assign cr_ready  = cr_pend & ~ac_pend;
   assign cr_hs     = bus.cr_valid_i & cr_ready;

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      if (rst_i) begin
         state         <= ST_IDLE;
         ac_pend       <= '0;
         cr_pend       <= '0;
         data_mask     <= '0;
         resp_agg      <= '0;
         addr_q        <= '0;
         prot_q        <= '0;
         snoop_q       <= '0;
         unsupported_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_hs) begin
                  addr_q        <= bus.req_addr_i;
                  prot_q        <= bus.req_prot_i;
                  snoop_q       <= enc_snoop;
                  resp_agg      <= '0;
                  data_mask     <= '0;
                  unsupported_q <= enc_unsupported;
                  if (enc_unsupported || (target_mask == '0)) begin
                     ac_pend     <= '0;
                     cr_pend     <= '0;
                     rsp_valid_q <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     ac_pend <= target_mask;
                     cr_pend <= target_mask;
                     state   <= ST_SNOOP;
                  end
               end
            end
            ST_SNOOP: begin
               ac_pend   <= ac_pend & ~ac_hs;
               cr_pend   <= cr_pend & ~cr_hs;
               resp_agg  <= resp_agg | cr_or;
               data_mask <= (data_mask & ~cr_hs) | (cr_dt & cr_hs);
               if ((cr_pend & ~cr_hs) == '0) begin
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o       = req_ready;
   assign bus.ac_valid_o        = ac_pend;
   assign bus.ac_addr_o         = addr_q;
   assign bus.ac_snoop_o        = snoop_q;
   assign bus.ac_prot_o         = prot_q;
   assign bus.cr_ready_o        = cr_ready;
   assign bus.rsp_valid_o       = rsp_valid_q;
   assign bus.rsp_resp_o        = resp_agg;
   assign bus.rsp_data_mask_o   = data_mask;
   assign bus.rsp_unsupported_o = unsupported_q;

endmodule
